cfu_pipe_arbiter: RTL and testbench
===================================

Name: cfu_pipe_arbiter

Overview:
- Shares one Level-1 (pipelined, fixed-latency, no req_ready/resp_ready) stateful CFU, such as the multiply-accumulate unit, among N requesters.
- Arbitrates round-robin and issues at most one request per cycle to the CFU.
- Routes each response back to its originating requester using an internal tag delay line.
- Because the CFU holds state (the accumulator), a requester can lock the CFU for an exclusive session; a timeout reclaims abandoned locks.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- CFU_FUNCTION_ID_W, 1, function id width
- CFU_REQ_RESP_ID_W, 6, request/response id width
- CFU_DATA_W, 32, width of each request operand and of the response data
- CFU_LATENCY, 3, fixed CFU latency in cycles (≥1)
- LOCK_TIMEOUT, 16, idle cycles before a lock is forcibly released; 0 disables the timeout

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester grant (combinational)
- req_lock  in  N_REQ  request acquires or holds exclusive ownership
- req_function_id  in  N_REQ*CFU_FUNCTION_ID_W  packed, requester i at slice i
- req_id  in  N_REQ*CFU_REQ_RESP_ID_W  packed
- req_data  in  N_REQ*2*CFU_DATA_W  packed, two operands per requester
- resp_valid  out  N_REQ  one-hot response strobe
- resp_id  out  CFU_REQ_RESP_ID_W  broadcast response id
- resp_data  out  CFU_DATA_W  broadcast response data
- resp_ok  out  1  broadcast response status
- cfu_req_valid  out  1  to CFU
- cfu_req_function_id  out  CFU_FUNCTION_ID_W  to CFU
- cfu_req_id  out  CFU_REQ_RESP_ID_W  to CFU
- cfu_req_data  out  2*CFU_DATA_W  to CFU
- cfu_clock_en  out  1  tied to 1
- cfu_resp_valid  in  1  from CFU
- cfu_resp_id  in  CFU_REQ_RESP_ID_W  from CFU
- cfu_resp_data  in  CFU_DATA_W  from CFU
- cfu_resp_ok  in  1  from CFU
- lock_timeout  out  1  one-cycle pulse on forced release
- err_unexpected  out  1  sticky error flag

Behaviour:
- Reset, clock: reset is synchronous, active-high, clocked by clock. On reset:
  - state ← IDLE; round-robin pointer ← 0; timer ← 0.
  - Tag delay line cleared.
  - All outputs 0, except cfu_clock_en = 1.
- Transfer: requester i transfers when req_valid[i] & req_ready[i]. req_ready is one-hot or zero.
- Pass-through: cfu_req_valid = any transfer. cfu_req_function_id, cfu_req_id and cfu_req_data are the winner's fields, muxed combinationally; they are 0 when there is no transfer.
- IDLE grant: the first valid requester at or after the pointer (mod N_REQ) is granted.
  - After each transfer, pointer ← winner+1 (mod N_REQ).
  - A transfer with req_lock=1 → state LOCKED, owner ← winner, timer ← 0.
- LOCKED grant: only the owner is eligible; req_ready of all others is 0.
  - Owner transfer with req_lock=1 → stay LOCKED, timer ← 0.
  - Owner transfer with req_lock=0 → that request issues, state → IDLE, pointer ← owner+1.
  - No owner transfer → timer increments.
  - If LOCK_TIMEOUT>0 and timer reaches LOCK_TIMEOUT-1 in a cycle with no owner transfer, the next state is IDLE, pointer ← owner+1, and lock_timeout pulses for exactly that first IDLE cycle.
- A lock is taken only by a transfer; req_lock without a transfer has no effect.
- Tag delay line: CFU_LATENCY stages, each holding {valid, requester index}. Stage 0 loads {transfer, winner} every cycle; stages shift every cycle.
- Response routing: when cfu_resp_valid=1 and the last stage is valid:
  - resp_valid[index] = 1; resp_id, resp_data and resp_ok pass through combinationally.
  - Otherwise resp_valid = 0 and resp_id/resp_data/resp_ok read 0.
- Error cases:
  - cfu_resp_valid=1 with the last stage invalid → err_unexpected set; it is cleared only by reset.
  - Last stage valid with cfu_resp_valid=0 → also sets err_unexpected.
- Back-pressure: requesters must accept responses unconditionally; the arbiter applies no response back-pressure.
- Throughput: one issue per cycle sustained (II=1). Issue-to-resp_valid latency equals CFU_LATENCY.
- Simultaneous events: a release request and another requester's valid in the same cycle → the other requester is granted no earlier than the next cycle.
- Reset mid-flight: in-flight tags are dropped. Responses the CFU emits after reset are flagged via err_unexpected only if the CFU itself was not reset; the CFU shares this reset.

Test Plan:
- N_REQ=2, LATENCY=3, MulAcc CFU. Requester 0 issues fn0, then fn1 (1,k) for k=1..4 back-to-back → resp_valid[0] on cycles issue+3, data 0,1,3,6,10; resp_valid[1] never asserted.
- Both requesters valid every cycle, lock=0 → grants 0,1,0,1,… starting with requester 0 after reset; each requester's responses route to its own resp_valid bit, resp_id preserved.
- Requester 1 issues with lock=1 for 5 requests while requester 0 is held valid → req_ready[0]=0 throughout; requester 1's 6th request (lock=0) issues; requester 0 is granted the next cycle; requester 1's accumulator sequence is uncorrupted.
- LOCK_TIMEOUT=8: requester 0 locks, then goes idle → exactly 8 cycles later state is IDLE; lock_timeout pulses one cycle; requester 1 is granted that cycle.
- Reset asserted with 2 requests in flight → no resp_valid after reset; pointer=0; err_unexpected=0; first grant after reset goes to requester 0.
- Bench forces cfu_resp_valid=1 with an empty delay line → err_unexpected=1 and stays 1; all resp_valid bits 0.

Source files
------------

// File: rtl/cfu_pipe_arbiter.sv
// +----------------------------------------------------------------------------+
// | cfu_pipe_arbiter: round-robin sharing of one fixed-latency stateful CFU,   |
// | with exclusive lock sessions and tag-routed responses.        Rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module cfu_pipe_arbiter #(
  parameter int N_REQ             = 2,
  parameter int CFU_FUNCTION_ID_W = 1,
  parameter int CFU_REQ_RESP_ID_W = 6,
  parameter int CFU_DATA_W        = 32,
  parameter int CFU_LATENCY       = 3,
  parameter int LOCK_TIMEOUT      = 16
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [N_REQ-1:0]                       req_valid,
  output logic [N_REQ-1:0]                       req_ready,
  input  logic [N_REQ-1:0]                       req_lock,
  input  logic [N_REQ*CFU_FUNCTION_ID_W-1:0]     req_function_id,
  input  logic [N_REQ*CFU_REQ_RESP_ID_W-1:0]     req_id,
  input  logic [N_REQ*2*CFU_DATA_W-1:0]          req_data,
  output logic [N_REQ-1:0]                       resp_valid,
  output logic [CFU_REQ_RESP_ID_W-1:0]           resp_id,
  output logic [CFU_DATA_W-1:0]                  resp_data,
  output logic                                   resp_ok,
  output logic                                   cfu_req_valid,
  output logic [CFU_FUNCTION_ID_W-1:0]           cfu_req_function_id,
  output logic [CFU_REQ_RESP_ID_W-1:0]           cfu_req_id,
  output logic [2*CFU_DATA_W-1:0]                cfu_req_data,
  output logic                                   cfu_clock_en,
  input  logic                                   cfu_resp_valid,
  input  logic [CFU_REQ_RESP_ID_W-1:0]           cfu_resp_id,
  input  logic [CFU_DATA_W-1:0]                  cfu_resp_data,
  input  logic                                   cfu_resp_ok,
  output logic                                   lock_timeout,
  output logic                                   err_unexpected
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam bit TMO_EN = (LOCK_TIMEOUT > 0);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(N_REQ - 1)) return '0;
    return i + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               lock_timeout_q, lock_timeout_d;
  logic               err_q, err_d;

  logic [CFU_LATENCY-1:0] tag_vld_q;
  logic [IDX_W-1:0]       tag_idx_q [CFU_LATENCY];

  logic [CFU_FUNCTION_ID_W-1:0] fid_a  [N_REQ];
  logic [CFU_REQ_RESP_ID_W-1:0] id_a   [N_REQ];
  logic [2*CFU_DATA_W-1:0]      data_a [N_REQ];

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic               resp_hit;

  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign fid_a[gi]  = req_function_id[gi*CFU_FUNCTION_ID_W +: CFU_FUNCTION_ID_W];
    assign id_a[gi]   = req_id[gi*CFU_REQ_RESP_ID_W +: CFU_REQ_RESP_ID_W];
    assign data_a[gi] = req_data[gi*2*CFU_DATA_W +: 2*CFU_DATA_W];
  end

  // While locked only the owner is eligible; otherwise scan from the pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = ptr_q;
    if (!reset) begin
      if (state_q == S_LOCKED) begin
        win_found = req_valid[owner_q];
        win_idx   = owner_q;
      end else begin
        for (int k = 0; k < N_REQ; k++) begin
          if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
          end
          cand = wrap_inc(cand);
        end
      end
    end
  end

  always_comb begin
    req_ready           = '0;
    cfu_req_valid       = win_found;
    cfu_req_function_id = '0;
    cfu_req_id          = '0;
    cfu_req_data        = '0;
    if (win_found) begin
      req_ready[win_idx]  = 1'b1;
      cfu_req_function_id = fid_a[win_idx];
      cfu_req_id          = id_a[win_idx];
      cfu_req_data        = data_a[win_idx];
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    timer_d        = timer_q;
    lock_timeout_d = 1'b0;
    if (win_found) ptr_d = wrap_inc(win_idx);
    case (state_q)
      S_IDLE: begin
        if (win_found && req_lock[win_idx]) begin
          state_d = S_LOCKED;
          owner_d = win_idx;
          timer_d = '0;
        end
      end
      S_LOCKED: begin
        if (win_found) begin
          timer_d = '0;
          if (!req_lock[win_idx]) state_d = S_IDLE;
        end else if (TMO_EN && (timer_q == TMR_LAST)) begin
          state_d        = S_IDLE;
          ptr_d          = wrap_inc(owner_q);
          timer_d        = '0;
          lock_timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      owner_q        <= '0;
      timer_q        <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      owner_q        <= owner_d;
      timer_q        <= timer_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  // Tag line mirrors the CFU pipeline so the last stage aligns with its output.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_vld_q <= '0;
      for (int s = 0; s < CFU_LATENCY; s++) tag_idx_q[s] <= '0;
    end else begin
      tag_vld_q[0] <= win_found;
      tag_idx_q[0] <= win_idx;
      for (int s = 1; s < CFU_LATENCY; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_idx_q[s] <= tag_idx_q[s-1];
      end
    end
  end

  assign resp_hit = !reset && cfu_resp_valid && tag_vld_q[CFU_LATENCY-1];

  always_comb begin
    resp_valid = '0;
    resp_id    = '0;
    resp_data  = '0;
    resp_ok    = 1'b0;
    if (resp_hit) begin
      resp_valid[tag_idx_q[CFU_LATENCY-1]] = 1'b1;
      resp_id   = cfu_resp_id;
      resp_data = cfu_resp_data;
      resp_ok   = cfu_resp_ok;
    end
  end

  assign err_d = err_q | (cfu_resp_valid ^ tag_vld_q[CFU_LATENCY-1]);

  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign cfu_clock_en   = 1'b1;
  assign lock_timeout   = lock_timeout_q;
  assign err_unexpected = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cfu_pipe_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_cfu_pipe_arbiter: directed bench with a 3-stage multiply-accumulate CFU |
// | model behind the arbiter.                                     Rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cfu_pipe_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_lock;
  logic [1:0]   req_function_id;
  logic [11:0]  req_id;
  logic [127:0] req_data;
  logic [1:0]   resp_valid;
  logic [5:0]   resp_id;
  logic [31:0]  resp_data;
  logic         resp_ok;
  logic         cfu_req_valid;
  logic [0:0]   cfu_req_function_id;
  logic [5:0]   cfu_req_id;
  logic [63:0]  cfu_req_data;
  logic         cfu_clock_en;
  logic         cfu_resp_valid;
  logic [5:0]   cfu_resp_id;
  logic [31:0]  cfu_resp_data;
  logic         cfu_resp_ok;
  logic         lock_timeout;
  logic         err_unexpected;

  logic         force_rv;
  logic         kill_rv;

  int n_chk  = 0;
  int n_pass = 0;

  int          tri_tab [6] = '{0, 1, 3, 6, 10, 15};
  logic [1:0]  e_rv;
  int          e_id;
  int          s;

  always #5 clock = ~clock;

  cfu_pipe_arbiter #(
    .N_REQ(2), .CFU_FUNCTION_ID_W(1), .CFU_REQ_RESP_ID_W(6),
    .CFU_DATA_W(32), .CFU_LATENCY(3), .LOCK_TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_function_id(req_function_id), .req_id(req_id), .req_data(req_data),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_ok(resp_ok),
    .cfu_req_valid(cfu_req_valid), .cfu_req_function_id(cfu_req_function_id),
    .cfu_req_id(cfu_req_id), .cfu_req_data(cfu_req_data), .cfu_clock_en(cfu_clock_en),
    .cfu_resp_valid(cfu_resp_valid), .cfu_resp_id(cfu_resp_id),
    .cfu_resp_data(cfu_resp_data), .cfu_resp_ok(cfu_resp_ok),
    .lock_timeout(lock_timeout), .err_unexpected(err_unexpected)
  );

  // Multiply-accumulate CFU: fn0 clears the accumulator, fn1 adds a*b; result after 3 cycles.
  logic        pv   [3];
  logic [5:0]  pid  [3];
  logic [31:0] pdat [3];
  logic [31:0] acc;
  wire  [31:0] nacc = (cfu_req_function_id == 1'b0) ? 32'd0
                    : acc + cfu_req_data[31:0] * cfu_req_data[63:32];

  always @(posedge clock) begin
    if (reset) begin
      acc   <= '0;
      pv[0] <= 1'b0;
      pv[1] <= 1'b0;
      pv[2] <= 1'b0;
    end else begin
      if (cfu_req_valid) acc <= nacc;
      pv[0] <= cfu_req_valid; pid[0] <= cfu_req_id; pdat[0] <= nacc;
      pv[1] <= pv[0];         pid[1] <= pid[0];     pdat[1] <= pdat[0];
      pv[2] <= pv[1];         pid[2] <= pid[1];     pdat[2] <= pdat[1];
    end
  end

  assign cfu_resp_valid = (pv[2] | force_rv) & ~kill_rv;
  assign cfu_resp_id    = pv[2] ? pid[2]  : 6'd0;
  assign cfu_resp_data  = pv[2] ? pdat[2] : 32'd0;
  assign cfu_resp_ok    = pv[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_reqs();
    req_valid = '0; req_lock = '0; req_function_id = '0; req_id = '0; req_data = '0;
  endtask

  task automatic set_req(input int i, input logic lk, input logic fn,
                         input logic [5:0] id, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]       = 1'b1;
    req_lock[i]        = lk;
    req_function_id[i] = fn;
    req_id[i*6 +: 6]   = id;
    req_data[i*64 +: 64] = {b, a};
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear_reqs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    force_rv = 1'b0;
    kill_rv  = 1'b0;
    do_reset();

    // Reset state
    #1;
    check("rst_ready",  64'(req_ready),      64'd0);
    check("rst_rv",     64'(resp_valid),     64'd0);
    check("rst_cfu_v",  64'(cfu_req_valid),  64'd0);
    check("rst_clk_en", 64'(cfu_clock_en),   64'd1);
    check("rst_tmo",    64'(lock_timeout),   64'd0);
    check("rst_err",    64'(err_unexpected), 64'd0);

    // Single requester accumulate sequence
    for (int t = 0; t < 8; t++) begin
      clear_reqs();
      if (t == 0)     set_req(0, 1'b0, 1'b0, 6'd1, 32'd0, 32'd0);
      else if (t < 5) set_req(0, 1'b0, 1'b1, 6'(t + 1), 32'd1, 32'(t));
      #1;
      if (t < 5) check("t1_ready", 64'(req_ready), 64'd1);
      if (t == 2) check("t1_cfu_data", 64'(cfu_req_data), {32'd2, 32'd1});
      if (t >= 3) begin
        check("t1_rv",   64'(resp_valid), 64'd1);
        check("t1_data", 64'(resp_data),  64'(tri_tab[t-3]));
        check("t1_id",   64'(resp_id),    64'(t - 2));
        check("t1_ok",   64'(resp_ok),    64'd1);
      end else begin
        check("t1_rv_idle", 64'(resp_valid), 64'd0);
      end
      step();
    end
    check("t1_err", 64'(err_unexpected), 64'd0);

    // Two requesters always valid, alternating grants
    do_reset();
    for (int t = 0; t < 9; t++) begin
      clear_reqs();
      if (t < 6) begin
        set_req(0, 1'b0, 1'b1, 6'(10 + t), 32'd0, 32'd0);
        set_req(1, 1'b0, 1'b1, 6'(20 + t), 32'd0, 32'd0);
      end
      #1;
      if (t < 6) begin
        e_rv = (t % 2 == 0) ? 2'b01 : 2'b10;
        e_id = (t % 2 == 0) ? 10 + t : 20 + t;
        check("t2_ready",  64'(req_ready),  64'(e_rv));
        check("t2_cfu_id", 64'(cfu_req_id), 64'(e_id));
      end
      if (t >= 3) begin
        s    = t - 3;
        e_rv = (s % 2 == 0) ? 2'b01 : 2'b10;
        e_id = (s % 2 == 0) ? 10 + s : 20 + s;
        check("t2_rv",  64'(resp_valid), 64'(e_rv));
        check("t2_rid", 64'(resp_id),    64'(e_id));
      end
      step();
    end

    // Locked session by requester 1 while requester 0 waits
    do_reset();
    for (int t = 0; t < 10; t++) begin
      clear_reqs();
      if (t < 6) set_req(1, (t < 5), (t != 0), 6'(30 + t), 32'd1, 32'(t));
      if (t >= 1 && t <= 6) set_req(0, 1'b0, 1'b0, 6'd40, 32'd0, 32'd0);
      #1;
      if (t < 6)  check("t3_ready1", 64'(req_ready), 64'd2);
      if (t == 6) check("t3_ready0", 64'(req_ready), 64'd1);
      if (t >= 3 && t <= 8) begin
        check("t3_rv",   64'(resp_valid), 64'd2);
        check("t3_data", 64'(resp_data),  64'(tri_tab[t-3]));
        check("t3_id",   64'(resp_id),    64'(27 + t));
      end
      if (t == 9) begin
        check("t3_rv0",   64'(resp_valid), 64'd1);
        check("t3_data0", 64'(resp_data),  64'd0);
        check("t3_id0",   64'(resp_id),    64'd40);
      end
      step();
    end

    // Abandoned lock reclaimed by timeout
    do_reset();
    for (int t = 0; t < 11; t++) begin
      clear_reqs();
      if (t == 0) set_req(0, 1'b1, 1'b0, 6'd50, 32'd0, 32'd0);
      else        set_req(1, 1'b0, 1'b0, 6'(t), 32'd0, 32'd0);
      #1;
      if (t == 0) check("t4_ready_lock", 64'(req_ready), 64'd1);
      if (t >= 1 && t <= 8) begin
        check("t4_ready_blocked", 64'(req_ready), 64'd0);
        check("t4_tmo_low",       64'(lock_timeout), 64'd0);
        check("t4_rv",            64'(resp_valid), (t == 3) ? 64'd1 : 64'd0);
      end
      if (t == 9) begin
        check("t4_ready_after", 64'(req_ready),    64'd2);
        check("t4_tmo_pulse",   64'(lock_timeout), 64'd1);
      end
      if (t == 10) check("t4_tmo_end", 64'(lock_timeout), 64'd0);
      step();
    end

    // Reset with two requests in flight
    do_reset();
    set_req(0, 1'b0, 1'b0, 6'd1, 32'd0, 32'd0);
    #1;
    check("t5_ready0", 64'(req_ready), 64'd1);
    step();
    clear_reqs();
    set_req(1, 1'b0, 1'b0, 6'd2, 32'd0, 32'd0);
    #1;
    check("t5_ready1", 64'(req_ready), 64'd2);
    step();
    clear_reqs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      #1;
      check("t5_rv",  64'(resp_valid),     64'd0);
      check("t5_err", 64'(err_unexpected), 64'd0);
      step();
    end
    set_req(0, 1'b0, 1'b0, 6'd3, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 6'd4, 32'd0, 32'd0);
    #1;
    check("t5_first_grant", 64'(req_ready), 64'd1);

    // Spurious CFU response with an empty tag line
    do_reset();
    force_rv = 1'b1;
    #1;
    check("t6_rv",     64'(resp_valid), 64'd0);
    check("t6_rdata",  64'(resp_data),  64'd0);
    check("t6_err_pre", 64'(err_unexpected), 64'd0);
    step();
    force_rv = 1'b0;
    #1;
    check("t6_err_set", 64'(err_unexpected), 64'd1);
    repeat (3) step();
    check("t6_err_sticky", 64'(err_unexpected), 64'd1);
    check("t6_rv_after",   64'(resp_valid),     64'd0);

    // Missing CFU response for an issued request
    do_reset();
    #1;
    check("t7_err_clear", 64'(err_unexpected), 64'd0);
    set_req(0, 1'b0, 1'b0, 6'd7, 32'd0, 32'd0);
    step();
    clear_reqs();
    step();
    step();
    kill_rv = 1'b1;
    #1;
    check("t7_rv", 64'(resp_valid), 64'd0);
    step();
    kill_rv = 1'b0;
    #1;
    check("t7_err_set", 64'(err_unexpected), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
